l2_arbiter: RTL and testbench

//  Two-master arbiter in front of the unified L2. Merges L1 I-cache and L1 D-cache

---
 rtl/rv32i_types.sv | 33 +++
 rtl/l2_arb_pick.sv | 34 +++
 rtl/l2_arbiter.sv | 108 ++++++++++
 tb/tb_l2_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared L2 request/return structs and L2 arbiter enums (L2_ARB_RR_EN selects arbiter tie-break)
package rv32i_types;

    localparam int s_offset = 5;
    localparam int s_mask   = 2**s_offset;
    localparam int s_line   = 8*s_mask;

    // Request bundle presented to the unified L2
    typedef struct packed {
        logic [31:0]       mem_address;
        logic [s_line-1:0] mem_wdata;
        logic              mem_read;
        logic              mem_write;
    } l2_go_t;

    // Completion bundle returned by the unified L2
    typedef struct packed {
        logic              mem_resp;
        logic [s_line-1:0] mem_rdata;
    } l2_ret_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } l2_arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } l2_arb_owner_t;

endpackage

// File: rtl/l2_arb_pick.sv
// rtl/l2_arb_pick.sv - owner select for the L2 arbiter; L2_ARB_RR_EN enables round-robin ties
module l2_arb_pick
    import rv32i_types::*;
(
    input  logic          i_req_i,
    input  logic          i_req_d,
    input  l2_arb_owner_t i_last_grant,
    output l2_arb_owner_t o_owner
);

`ifdef L2_ARB_RR_EN
    // On a tie the master that did not win last time is chosen
    always_comb begin
        o_owner = OWN_D;
        if (i_req_i && i_req_d) begin
            o_owner = (i_last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (i_req_i) begin
            o_owner = OWN_I;
        end
    end
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = (i_last_grant == OWN_D);

    // D-cache always wins a tie; I only when D is not asking
    always_comb begin
        o_owner = OWN_D;
        if (i_req_i && !i_req_d) begin
            o_owner = OWN_I;
        end
    end
`endif

endmodule

// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - two-master (I/D) arbiter in front of the unified L2; L2_ARB_RR_EN selects round-robin ties
module l2_arbiter
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic [31:0]       i_mem_addr,
    output logic [s_line-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [31:0]       d_mem_addr,
    input  logic [s_line-1:0] d_mem_wdata,
    output logic [s_line-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output l2_go_t            l2_go,
    input  l2_ret_t           l2_ret
);

    l2_arb_state_t r_state;
    l2_arb_owner_t r_owner;
    l2_arb_owner_t r_last_grant;
    l2_go_t        r_go;

    logic          w_req_i;
    logic          w_req_d;
    l2_arb_owner_t w_pick;
    logic          w_in_grant;

    assign w_req_i    = i_mem_read;
    assign w_req_d    = d_mem_read | d_mem_write;
    assign w_in_grant = (r_state == GRANT);

    l2_arb_pick u_pick (
        .i_req_i      (w_req_i),
        .i_req_d      (w_req_d),
        .i_last_grant (r_last_grant),
        .o_owner      (w_pick)
    );

    // Transaction FSM: latch owner and its request on grant, release after L2 completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= OWN_I;
            r_last_grant <= OWN_I;
            r_go         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_i || w_req_d) begin
                        r_state      <= GRANT;
                        r_owner      <= w_pick;
                        r_last_grant <= w_pick;
                        if (w_pick == OWN_D) begin
                            r_go.mem_address <= d_mem_addr;
                            r_go.mem_wdata   <= d_mem_wdata;
                            // A simultaneous read+write from D is illegal; the write wins
                            r_go.mem_read    <= d_mem_read & ~d_mem_write;
                            r_go.mem_write   <= d_mem_write;
                        end else begin
                            r_go.mem_address <= i_mem_addr;
                            r_go.mem_wdata   <= '0;
                            r_go.mem_read    <= 1'b1;
                            r_go.mem_write   <= 1'b0;
                        end
                    end
                end
                GRANT: begin
                    if (l2_ret.mem_resp) begin
                        r_state        <= DONE;
                        r_go.mem_read  <= 1'b0;
                        r_go.mem_write <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state        <= IDLE;
                    r_go.mem_read  <= 1'b0;
                    r_go.mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign l2_go = r_go;

    // Steer the L2 completion to the current owner only while a grant is open
    always_comb begin
        i_mem_resp  = 1'b0;
        d_mem_resp  = 1'b0;
        i_mem_rdata = '0;
        d_mem_rdata = '0;
        if (w_in_grant) begin
            if (r_owner == OWN_I) begin
                i_mem_resp  = l2_ret.mem_resp;
                i_mem_rdata = l2_ret.mem_rdata;
            end else begin
                d_mem_resp  = l2_ret.mem_resp;
                d_mem_rdata = l2_ret.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb/tb_l2_arbiter.sv - randomized self-checking bench for l2_arbiter against a transaction-level model
module tb_l2_arbiter;
    import rv32i_types::*;

    logic              clk;
    logic              rst_n;
    logic              i_mem_read;
    logic [31:0]       i_mem_addr;
    logic [s_line-1:0] i_mem_rdata;
    logic              i_mem_resp;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [31:0]       d_mem_addr;
    logic [s_line-1:0] d_mem_wdata;
    logic [s_line-1:0] d_mem_rdata;
    logic              d_mem_resp;
    l2_go_t            l2_go;
    l2_ret_t           l2_ret;

    int n_err = 0;
    int n_chk = 0;

    // Model: what each L1 is currently asking for, and who won the last grant
    bit                i_pend;
    bit                d_pend;
    logic [31:0]       mi_addr;
    logic [31:0]       md_addr;
    bit                md_rd;
    bit                md_wr;
    logic [s_line-1:0] md_wdata;
    bit                m_last_d;

    l2_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_read  (i_mem_read),
        .i_mem_addr  (i_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_resp  (i_mem_resp),
        .d_mem_read  (d_mem_read),
        .d_mem_write (d_mem_write),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_rdata (d_mem_rdata),
        .d_mem_resp  (d_mem_resp),
        .l2_go       (l2_go),
        .l2_ret      (l2_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [289:0] got, input logic [289:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [s_line-1:0] rand_line();
        logic [s_line-1:0] r;
        for (int k = 0; k < s_line/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise_i(input logic [31:0] addr);
        i_pend     = 1'b1;
        mi_addr    = addr;
        i_mem_read = 1'b1;
        i_mem_addr = addr;
    endtask

    task automatic raise_d(input bit rd, input bit wr, input logic [31:0] addr, input logic [s_line-1:0] wd);
        d_pend      = 1'b1;
        md_rd       = rd;
        md_wr       = wr;
        md_addr     = addr;
        md_wdata    = wd;
        d_mem_read  = rd;
        d_mem_write = wr;
        d_mem_addr  = addr;
        d_mem_wdata = wd;
    endtask

    task automatic raise_d_rand();
        int kind;
        kind = $urandom_range(0, 2);
        raise_d(kind != 1, kind != 0, {$urandom} & 32'hFFFF_FFE0, rand_line());
    endtask

    // Who the arbitration rules say wins next, given what is pending
    function automatic bit pick_d();
        if (i_pend && d_pend) begin
`ifdef L2_ARB_RR_EN
            return !m_last_d;
`else
            return 1'b1;
`endif
        end
        return d_pend;
    endfunction

    function automatic l2_go_t exp_go(input bit own_d);
        l2_go_t g;
        if (own_d) begin
            g.mem_address = md_addr;
            g.mem_wdata   = md_wdata;
            g.mem_read    = md_rd & ~md_wr;
            g.mem_write   = md_wr;
        end else begin
            g.mem_address = mi_addr;
            g.mem_wdata   = '0;
            g.mem_read    = 1'b1;
            g.mem_write   = 1'b0;
        end
        return g;
    endfunction

    // One full transaction starting from IDLE with at least one request pending
    task automatic do_txn(input int lat, input logic [s_line-1:0] rd, input bit mutate,
                          input bit spurious_done, input bit d_mid);
        bit     own_d;
        l2_go_t eg;
        own_d    = pick_d();
        m_last_d = own_d;
        eg       = exp_go(own_d);
        step();
        check("grant_go", l2_go, eg);
        if (mutate) begin
            if (own_d) d_mem_addr = 32'hFFFF_FFE0;
            else       i_mem_addr = 32'hFFFF_FFE0;
        end
        if (d_mid && !own_d && !d_pend) raise_d_rand();
        for (int c = 0; c < lat; c++) begin
            step();
            check("hold_go", l2_go, eg);
            check("wait_resp", {i_mem_resp, d_mem_resp}, 2'b00);
        end
        l2_ret.mem_rdata = rd;
        l2_ret.mem_resp  = 1'b1;
        #1;
        check("owner_resp",  own_d ? d_mem_resp  : i_mem_resp, 1'b1);
        check("other_resp",  own_d ? i_mem_resp  : d_mem_resp, 1'b0);
        check("owner_rdata", own_d ? d_mem_rdata : i_mem_rdata, rd);
        check("other_rdata", own_d ? i_mem_rdata : d_mem_rdata, '0);
        step();
        l2_ret.mem_resp = spurious_done;
        if (own_d) begin
            d_pend = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
        end else begin
            i_pend = 1'b0; i_mem_read = 1'b0;
        end
        #1;
        check("done_rw",   {l2_go.mem_read, l2_go.mem_write}, 2'b00);
        check("done_resp", {i_mem_resp, d_mem_resp}, 2'b00);
        l2_ret.mem_resp = 1'b0;
        step();
        check("idle_rw", {l2_go.mem_read, l2_go.mem_write}, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        i_mem_read = 1'b0; i_mem_addr = '0;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
        l2_ret = '0;
        i_pend = 1'b0; d_pend = 1'b0; m_last_d = 1'b0;

        // Reset with an I request held; L2 even signals resp, nothing may leak out
        raise_i(32'h0000_1000);
        l2_ret.mem_resp  = 1'b1;
        l2_ret.mem_rdata = rand_line();
        repeat (3) step();
        check("rst_go",    l2_go, '0);
        check("rst_resp",  {i_mem_resp, d_mem_resp}, 2'b00);
        check("rst_irdat", i_mem_rdata, '0);
        check("rst_drdat", d_mem_rdata, '0);
        l2_ret.mem_resp = 1'b0;
        rst_n = 1'b1;

        // I read of 0x1000, L2 answers after 10 cycles
        do_txn(10, {8{32'hDEADBEEF}}, 1'b0, 1'b0, 1'b0);

        // D writeback
        raise_d(1'b0, 1'b1, 32'h8000_0040, {8{32'hA5A5A5A5}});
        do_txn(4, rand_line(), 1'b0, 1'b0, 1'b0);

        // Simultaneous I and D requests, three rounds, each served to completion
        for (int r = 0; r < 3; r++) begin
            if (!i_pend) raise_i({$urandom} & 32'hFFFF_FFE0);
            if (!d_pend) raise_d_rand();
            while (i_pend || d_pend) do_txn($urandom_range(0, 3), rand_line(), 1'b0, 1'b0, 1'b0);
        end

        // I address changes mid-flight, D arrives during I's grant
        raise_i(32'h0000_2000);
        do_txn(5, rand_line(), 1'b1, 1'b0, 1'b1);
        while (i_pend || d_pend) do_txn(2, rand_line(), 1'b0, 1'b0, 1'b0);

        // Spurious L2 completion while idle
        l2_ret.mem_resp = 1'b1;
        #1;
        check("spur_idle_resp", {i_mem_resp, d_mem_resp}, 2'b00);
        step();
        check("spur_idle_rw", {l2_go.mem_read, l2_go.mem_write}, 2'b00);
        l2_ret.mem_resp = 1'b0;

        // Random traffic
        for (int t = 0; t < 30; t++) begin
            if (!i_pend && $urandom_range(0, 1)) raise_i({$urandom} & 32'hFFFF_FFE0);
            if (!d_pend && $urandom_range(0, 1)) raise_d_rand();
            if (!i_pend && !d_pend) raise_i({$urandom} & 32'hFFFF_FFE0);
            do_txn($urandom_range(0, 5), rand_line(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        while (i_pend || d_pend) do_txn(1, rand_line(), 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a grant clears outputs at once
        raise_i(32'h0000_3000);
        step();
        check("pre_rst_go", l2_go, exp_go(1'b0));
        #2;
        rst_n = 1'b0;
        l2_ret.mem_resp = 1'b1;
        #1;
        check("async_go",   l2_go, '0);
        check("async_resp", {i_mem_resp, d_mem_resp}, 2'b00);
        l2_ret.mem_resp = 1'b0;
        i_pend = 1'b0; i_mem_read = 1'b0; m_last_d = 1'b0;
        step();
        rst_n = 1'b1;

        // After reset D wins the first tie in either mode
        raise_i({$urandom} & 32'hFFFF_FFE0);
        raise_d_rand();
        while (i_pend || d_pend) do_txn(1, rand_line(), 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
